// File: rtl/multicycle_control_unit_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit_if
// Purpose : groups the instruction/data-memory handshakes and every control
//           strobe of the multi-cycle control unit into one bundle.
// Modports: master - the control unit (consumes run/handshakes, drives controls)
//           slave  - the datapath / memories / bench (drives run/handshakes)
// Signals : run, instruction, instr_ready, mem_ready (towards the unit);
//           ir_write, pc_inc, pc_load, reg_a/b_select, write_enable, reg_clear,
//           g_select, mb_select, md_select, mem_read, mem_write, out_enable,
//           constant_in, set_value, illegal, state (from the unit).
// ----------------------------------------------------------------------------
interface multicycle_control_unit_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int REG_SEL_WIDTH = 3,
   parameter int OPCODE_WIDTH  = 4
);
   localparam int NUM_REGS    = 2 ** REG_SEL_WIDTH;
   localparam int INSTR_WIDTH = OPCODE_WIDTH + 2 * REG_SEL_WIDTH;

   logic                     run;
   logic [INSTR_WIDTH-1:0]   instruction;
   logic                     instr_ready;
   logic                     mem_ready;
   logic                     ir_write;
   logic                     pc_inc;
   logic                     pc_load;
   logic [REG_SEL_WIDTH-1:0] reg_a_select;
   logic [REG_SEL_WIDTH-1:0] reg_b_select;
   logic [NUM_REGS-1:0]      write_enable;
   logic                     reg_clear;
   logic [3:0]               g_select;
   logic                     mb_select;
   logic                     md_select;
   logic                     mem_read;
   logic                     mem_write;
   logic                     out_enable;
   logic [DATA_WIDTH-1:0]    constant_in;
   logic [DATA_WIDTH-1:0]    set_value;
   logic                     illegal;
   logic [2:0]               state;

   modport master (
      input  run, instruction, instr_ready, mem_ready,
      output ir_write, pc_inc, pc_load, reg_a_select, reg_b_select, write_enable,
             reg_clear, g_select, mb_select, md_select, mem_read, mem_write,
             out_enable, constant_in, set_value, illegal, state
   );

   modport slave (
      output run, instruction, instr_ready, mem_ready,
      input  ir_write, pc_inc, pc_load, reg_a_select, reg_b_select, write_enable,
             reg_clear, g_select, mb_select, md_select, mem_read, mem_write,
             out_enable, constant_in, set_value, illegal, state
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit
// Purpose : sequences each instruction through FETCH/DECODE/EXECUTE/MEM/
//           WRITEBACK, holding it in an internal IR, waiting on the instruction
//           and data memory handshakes and trapping on illegal opcodes.
// Ports   : clk     - system clock, rising edge
//           reset   - asynchronous, active-high
//           ctrl_if - multicycle_control_unit_if.master (handshakes + controls)
// All control outputs are decoded combinationally from the state and IR
// registers only, except pc_inc which also qualifies on instr_ready.
// ----------------------------------------------------------------------------
module multicycle_control_unit #(
   parameter int DATA_WIDTH    = 8,
   parameter int REG_SEL_WIDTH = 3,
   parameter int OPCODE_WIDTH  = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   multicycle_control_unit_if.master   ctrl_if
);
   localparam int NUM_REGS    = 2 ** REG_SEL_WIDTH;
   localparam int INSTR_WIDTH = OPCODE_WIDTH + 2 * REG_SEL_WIDTH;

   localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(4'd0);
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = OPCODE_WIDTH'(4'd1);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(4'd2);
   localparam logic [OPCODE_WIDTH-1:0] OP_SUBI  = OPCODE_WIDTH'(4'd3);
   localparam logic [OPCODE_WIDTH-1:0] OP_MUL2  = OPCODE_WIDTH'(4'd4);
   localparam logic [OPCODE_WIDTH-1:0] OP_DIV2  = OPCODE_WIDTH'(4'd5);
   localparam logic [OPCODE_WIDTH-1:0] OP_CLR   = OPCODE_WIDTH'(4'd6);
   localparam logic [OPCODE_WIDTH-1:0] OP_RST   = OPCODE_WIDTH'(4'd7);
   localparam logic [OPCODE_WIDTH-1:0] OP_MOV   = OPCODE_WIDTH'(4'd8);
   localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = OPCODE_WIDTH'(4'd9);
   localparam logic [OPCODE_WIDTH-1:0] OP_OUT   = OPCODE_WIDTH'(4'd10);
   localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(4'd11);
   localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(4'd12);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEM       = 3'd4,
      S_WRITEBACK = 3'd5,
      S_TRAP      = 3'd6
   } state_t;

   state_t                   state_q, state_d;
   logic [INSTR_WIDTH-1:0]   ir_q, ir_d;
   logic [OPCODE_WIDTH-1:0]  opcode_s;
   logic [REG_SEL_WIDTH-1:0] field_a_s;
   logic [REG_SEL_WIDTH-1:0] field_b_s;

   // Opcodes 13 and above (including any with upper opcode bits set) are illegal.
   function automatic logic is_legal_op(input logic [OPCODE_WIDTH-1:0] op);
      return (op <= OP_STORE);
   endfunction

   // Instructions whose result lands in register field A.
   function automatic logic writes_field_a(input logic [OPCODE_WIDTH-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_MUL2, OP_DIV2,
         OP_CLR, OP_MOV, OP_LOAD: return 1'b1;
         default:                 return 1'b0;
      endcase
   endfunction

   // ALU function code; non-ALU instructions leave the ALU in pass-B.
   function automatic logic [3:0] alu_fn(input logic [OPCODE_WIDTH-1:0] op);
      case (op)
         OP_ADD, OP_ADDI: return 4'b0010;
         OP_SUB, OP_SUBI: return 4'b0101;
         OP_MUL2:         return 4'b1000;
         OP_DIV2:         return 4'b1001;
         default:         return 4'b0000;
      endcase
   endfunction

   assign opcode_s  = ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];
   assign field_a_s = ir_q[2*REG_SEL_WIDTH-1 -: REG_SEL_WIDTH];
   assign field_b_s = ir_q[REG_SEL_WIDTH-1:0];

   // Field-derived outputs come straight from the IR, so reset clears them too.
   assign ctrl_if.reg_a_select = field_a_s;
   assign ctrl_if.reg_b_select = field_b_s;
   assign ctrl_if.constant_in  = DATA_WIDTH'(field_b_s);
   assign ctrl_if.set_value    = DATA_WIDTH'({field_a_s, field_b_s});
   assign ctrl_if.state        = state_q;

   // State and instruction register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ir_q    <= {INSTR_WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Next-state and control decode.
   always_comb begin
      state_d              = state_q;
      ir_d                 = ir_q;
      ctrl_if.ir_write     = 1'b0;
      ctrl_if.pc_inc       = 1'b0;
      ctrl_if.pc_load      = 1'b0;
      ctrl_if.write_enable = {NUM_REGS{1'b0}};
      ctrl_if.reg_clear    = 1'b0;
      ctrl_if.g_select     = 4'b0000;
      ctrl_if.mb_select    = 1'b0;
      ctrl_if.md_select    = 1'b0;
      ctrl_if.mem_read     = 1'b0;
      ctrl_if.mem_write    = 1'b0;
      ctrl_if.out_enable   = 1'b0;
      ctrl_if.illegal      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (ctrl_if.run) state_d = S_FETCH;
            else             state_d = S_IDLE;
         end
         S_FETCH: begin
            ctrl_if.ir_write = 1'b1;
            if (ctrl_if.instr_ready) begin
               ir_d           = ctrl_if.instruction;
               ctrl_if.pc_inc = 1'b1;
               state_d        = S_DECODE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            if (is_legal_op(opcode_s)) state_d = S_EXECUTE;
            else                       state_d = S_TRAP;
         end
         S_EXECUTE: begin
            ctrl_if.g_select  = alu_fn(opcode_s);
            ctrl_if.mb_select = (opcode_s == OP_ADDI) || (opcode_s == OP_SUBI);
            case (opcode_s)
               OP_JMP: begin
                  ctrl_if.pc_load = 1'b1;
                  state_d         = S_FETCH;
               end
               OP_OUT: begin
                  ctrl_if.out_enable = 1'b1;
                  state_d            = S_FETCH;
               end
               OP_LOAD, OP_STORE: state_d = S_MEM;
               default:           state_d = S_WRITEBACK;
            endcase
         end
         S_MEM: begin
            // Only LOAD and STORE reach MEM, so "not LOAD" means STORE.
            if (opcode_s == OP_LOAD) ctrl_if.mem_read  = 1'b1;
            else                     ctrl_if.mem_write = 1'b1;
            if (!ctrl_if.mem_ready)            state_d = S_MEM;
            else if (opcode_s == OP_LOAD)      state_d = S_WRITEBACK;
            else                               state_d = S_FETCH;
         end
         S_WRITEBACK: begin
            // ALU controls stay valid so the result being written is stable.
            ctrl_if.g_select  = alu_fn(opcode_s);
            ctrl_if.mb_select = (opcode_s == OP_ADDI) || (opcode_s == OP_SUBI);
            ctrl_if.md_select = (opcode_s == OP_LOAD);
            ctrl_if.reg_clear = (opcode_s == OP_CLR) || (opcode_s == OP_RST);
            if (opcode_s == OP_RST)
               ctrl_if.write_enable = {NUM_REGS{1'b1}};
            else if (writes_field_a(opcode_s))
               ctrl_if.write_enable = {{(NUM_REGS-1){1'b0}}, 1'b1} << field_a_s;
            else
               ctrl_if.write_enable = {NUM_REGS{1'b0}};
            state_d = S_FETCH;
         end
         S_TRAP: begin
            ctrl_if.illegal = 1'b1;
            state_d         = S_TRAP;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multicycle_control_unit_if #(.DATA_WIDTH(8), .REG_SEL_WIDTH(3), .OPCODE_WIDTH(4)) bus ();
   multicycle_control_unit #(.DATA_WIDTH(8), .REG_SEL_WIDTH(3), .OPCODE_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .ctrl_if(bus.master)
   );

   multicycle_control_unit_if #(.DATA_WIDTH(12), .REG_SEL_WIDTH(4), .OPCODE_WIDTH(4)) bus_w ();
   multicycle_control_unit #(.DATA_WIDTH(12), .REG_SEL_WIDTH(4), .OPCODE_WIDTH(4)) dut_w (
      .clk(clk), .reset(reset), .ctrl_if(bus_w.master)
   );

   // Control vector bit masks: {ir_write,pc_inc,pc_load,out_enable,mem_read,
   // mem_write,md_select,mb_select,reg_clear,illegal,g_select[3:0]}
   localparam logic [13:0] IRW = 14'h2000;
   localparam logic [13:0] PCI = 14'h1000;
   localparam logic [13:0] PCL = 14'h0800;
   localparam logic [13:0] OE  = 14'h0400;
   localparam logic [13:0] MR  = 14'h0200;
   localparam logic [13:0] MW  = 14'h0100;
   localparam logic [13:0] MD  = 14'h0080;
   localparam logic [13:0] MB  = 14'h0040;
   localparam logic [13:0] RC  = 14'h0020;
   localparam logic [13:0] ILL = 14'h0010;

   typedef struct packed {
      logic [2:0]  st;
      logic        ir_rdy;
      logic        m_rdy;
      logic [13:0] ctrl;
      logic [7:0]  we;
      logic        chk;
      logic [7:0]  ci;
      logic [7:0]  sv;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // ALU/CLR table: opcode, A, B, g_select, mb_select, reg_clear
   logic [3:0] t_op [6] = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd8, 4'd6};
   logic [2:0] t_a  [6] = '{3'd0, 3'd1, 3'd4, 3'd6, 3'd7, 3'd4};
   logic [2:0] t_b  [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd0};
   logic [3:0] t_g  [6] = '{4'h5, 4'h5, 4'h8, 4'h9, 4'h0, 4'h0};
   logic       t_mb [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   logic       t_rc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [13:0] obs_ctrl();
      return {bus.ir_write, bus.pc_inc, bus.pc_load, bus.out_enable, bus.mem_read,
              bus.mem_write, bus.md_select, bus.mb_select, bus.reg_clear, bus.illegal,
              bus.g_select};
   endfunction

   function automatic exp_t rec(input logic [2:0] st, input logic ir_rdy, input logic m_rdy,
                                input logic [13:0] c, input logic [7:0] we);
      exp_t r;
      r        = '0;
      r.st     = st;
      r.ir_rdy = ir_rdy;
      r.m_rdy  = m_rdy;
      r.ctrl   = c;
      r.we     = we;
      return r;
   endfunction

   // Load the instruction and queue the FETCH and DECODE cycles.
   task automatic push_fd(input logic [9:0] instr);
      bus.instruction = instr;
      sb_q.push_back(rec(3'd1, 1'b1, 1'b0, IRW | PCI, 8'h00));
      sb_q.push_back(rec(3'd2, 1'b1, 1'b0, 14'h0000, 8'h00));
   endtask

   // Pop one expectation per cycle, apply its handshake inputs, compare.
   task automatic run_q(input string name);
      exp_t e;
      int   idx;
      idx = 0;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         bus.instr_ready = e.ir_rdy;
         bus.mem_ready   = e.m_rdy;
         #1;
         check_val($sformatf("%s.c%0d.state", name, idx), {29'd0, bus.state}, {29'd0, e.st});
         check_val($sformatf("%s.c%0d.ctrl", name, idx), {18'd0, obs_ctrl()}, {18'd0, e.ctrl});
         check_val($sformatf("%s.c%0d.we", name, idx), {24'd0, bus.write_enable}, {24'd0, e.we});
         if (e.chk) begin
            check_val($sformatf("%s.c%0d.const", name, idx), {24'd0, bus.constant_in}, {24'd0, e.ci});
            check_val($sformatf("%s.c%0d.setv", name, idx), {24'd0, bus.set_value}, {24'd0, e.sv});
         end
         idx++;
         @(negedge clk);
      end
   endtask

   initial begin
      exp_t r;
      logic [9:0] ins;
      logic [7:0] we_exp;
      reset = 1'b1;
      bus.run = 1'b0; bus.instruction = 10'd0; bus.instr_ready = 1'b0; bus.mem_ready = 1'b0;
      bus_w.run = 1'b0; bus_w.instruction = 12'd0; bus_w.instr_ready = 1'b0; bus_w.mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst.state", {29'd0, bus.state}, 32'd0);
      check_val("rst.ctrl", {18'd0, obs_ctrl()}, 32'd0);
      check_val("rst.we", {24'd0, bus.write_enable}, 32'd0);
      check_val("rst.setv", {24'd0, bus.set_value}, 32'd0);

      reset = 1'b0;
      @(negedge clk);
      check_val("idle_no_run", {29'd0, bus.state}, 32'd0);
      bus.run = 1'b1; bus.instr_ready = 1'b1;
      @(negedge clk);
      bus.run = 1'b0;  // ignored outside IDLE

      // ADD A=3 B=5
      push_fd(10'b0000011101);
      sb_q.push_back(rec(3'd3, 1'b1, 1'b0, 14'h0002, 8'h00));
      sb_q.push_back(rec(3'd5, 1'b1, 1'b0, 14'h0002, 8'h08));
      run_q("ADD");

      // FETCH stall for two cycles, then ADDI A=2 B=7
      bus.instruction = 10'b0010010111;
      sb_q.push_back(rec(3'd1, 1'b0, 1'b0, IRW, 8'h00));
      sb_q.push_back(rec(3'd1, 1'b0, 1'b0, IRW, 8'h00));
      push_fd(10'b0010010111);
      r = rec(3'd3, 1'b1, 1'b0, MB | 14'h0002, 8'h00);
      r.chk = 1'b1; r.ci = 8'h07; r.sv = 8'h17;
      sb_q.push_back(r);
      sb_q.push_back(rec(3'd5, 1'b1, 1'b0, MB | 14'h0002, 8'h04));
      run_q("ADDI");

      // ALU / MOV / CLR table
      for (int i = 0; i < 6; i++) begin
         ins    = {t_op[i], t_a[i], t_b[i]};
         we_exp = 8'h01 << t_a[i];
         push_fd(ins);
         sb_q.push_back(rec(3'd3, 1'b1, 1'b0, {10'd0, t_g[i]} | (t_mb[i] ? MB : 14'h0000), 8'h00));
         sb_q.push_back(rec(3'd5, 1'b1, 1'b0, {10'd0, t_g[i]} | (t_mb[i] ? MB : 14'h0000)
                                             | (t_rc[i] ? RC : 14'h0000), we_exp));
         run_q($sformatf("ALU%0d", i));
      end

      // LOAD A=5 B=1 with three mem_ready-low cycles
      push_fd(10'b1011101001);
      sb_q.push_back(rec(3'd3, 1'b1, 1'b0, 14'h0000, 8'h00));
      for (int i = 0; i < 3; i++) sb_q.push_back(rec(3'd4, 1'b1, 1'b0, MR, 8'h00));
      sb_q.push_back(rec(3'd4, 1'b1, 1'b1, MR, 8'h00));
      sb_q.push_back(rec(3'd5, 1'b1, 1'b0, MD, 8'h20));
      run_q("LOAD");

      // STORE A=2 B=3, memory ready at once
      push_fd(10'b1100010011);
      sb_q.push_back(rec(3'd3, 1'b1, 1'b0, 14'h0000, 8'h00));
      sb_q.push_back(rec(3'd4, 1'b1, 1'b1, MW, 8'h00));
      run_q("STORE");

      // JMP {A,B}=000111
      push_fd(10'b1001000111);
      r = rec(3'd3, 1'b1, 1'b0, PCL, 8'h00);
      r.chk = 1'b1; r.ci = 8'h07; r.sv = 8'h07;
      sb_q.push_back(r);
      run_q("JMP");

      // OUT
      push_fd(10'b1010011000);
      sb_q.push_back(rec(3'd3, 1'b1, 1'b0, OE, 8'h00));
      run_q("OUT");

      // RST
      push_fd(10'b0111000000);
      sb_q.push_back(rec(3'd3, 1'b1, 1'b0, 14'h0000, 8'h00));
      sb_q.push_back(rec(3'd5, 1'b1, 1'b0, RC, 8'hFF));
      run_q("RST");

      // Illegal opcode: TRAP is sticky
      push_fd(10'b1111111111);
      for (int i = 0; i < 3; i++) sb_q.push_back(rec(3'd6, 1'b1, 1'b0, ILL, 8'h00));
      run_q("TRAP");
      reset = 1'b1;
      #1;
      check_val("trap_rst.state", {29'd0, bus.state}, 32'd0);
      check_val("trap_rst.ctrl", {18'd0, obs_ctrl()}, 32'd0);
      check_val("trap_rst.ir", {24'd0, bus.set_value}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      bus.run = 1'b1;
      @(negedge clk);
      bus.run = 1'b0;

      // STORE stalled in MEM, then reset mid-instruction
      push_fd(10'b1100001010);
      sb_q.push_back(rec(3'd3, 1'b1, 1'b0, 14'h0000, 8'h00));
      sb_q.push_back(rec(3'd4, 1'b1, 1'b0, MW, 8'h00));
      sb_q.push_back(rec(3'd4, 1'b1, 1'b0, MW, 8'h00));
      run_q("STORE_STALL");
      check_val("mid_store.mw", {31'd0, bus.mem_write}, 32'd1);
      reset = 1'b1;
      #1;
      check_val("mid_rst.state", {29'd0, bus.state}, 32'd0);
      check_val("mid_rst.mw", {31'd0, bus.mem_write}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Wide build: ADD A=9 writes register 9 only
      bus_w.run = 1'b1; bus_w.instr_ready = 1'b1; bus_w.instruction = 12'b0000_1001_0000;
      @(negedge clk);
      bus_w.run = 1'b0;
      check_val("w.fetch", {29'd0, bus_w.state}, 32'd1);
      @(negedge clk);
      check_val("w.decode", {29'd0, bus_w.state}, 32'd2);
      @(negedge clk);
      check_val("w.exec", {29'd0, bus_w.state}, 32'd3);
      check_val("w.exec_we", {16'd0, bus_w.write_enable}, 32'd0);
      @(negedge clk);
      check_val("w.wb", {29'd0, bus_w.state}, 32'd5);
      check_val("w.wb_we", {16'd0, bus_w.write_enable}, 32'h0000_0200);
      check_val("w.narrow_idle", {29'd0, bus.state}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
